// File: rtl/mem_pkg.sv
// Shared definitions for the main_memory backing-store model.
//   state_e        : controller states (IDLE, WAIT, RESPOND)
//   WORD_BYTES     : bytes per stored 64-bit word
//   OFFSET_BITS    : byte-offset bits below the word index
//   addr_to_index  : byte address -> word index, wrapped modulo depth
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RESPOND = 2'd2
  } state_e;

  localparam int unsigned WORD_BYTES  = 32'd8;
  localparam int unsigned OFFSET_BITS = 32'd3;

  // Drop the byte offset and wrap into the array; depth is a power of two.
  function automatic logic [31:0] addr_to_index(input logic [31:0] addr,
                                                input int unsigned depth);
    return (addr >> OFFSET_BITS) & (depth - 32'd1);
  endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port DEPTH x 64 storage with a registered read port.
//   clk   : clock
//   rst   : asynchronous active-low reset (clears only the read register)
//   en    : access strobe, high for exactly the response edge
//   we    : 1 = write wdata at index, 0 = load rdata from index
//   index : word index
//   wdata : write data
//   rdata : registered read data, held until the next enabled read
module mem_array #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned IDX_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             we,
  input  logic [IDX_W-1:0] index,
  input  logic [63:0]      wdata,
  output logic [63:0]      rdata
);

  logic [63:0] mem_r [DEPTH];
  logic [63:0] rdata_r;

  // Storage write; contents intentionally survive reset.
  always_ff @(posedge clk) begin
    if (en && we) begin
      mem_r[index] <= wdata;
    end
  end

  // Read register; only an enabled read replaces the held value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_r <= 64'd0;
    end else if (en && !we) begin
      rdata_r <= mem_r[index];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/main_memory.sv
// Backing store behind the cache controller: one request at a time over a
// req/ready handshake with a fixed response latency.
//   clk            : clock
//   rst            : asynchronous active-low reset
//   ram_req        : request strobe, only accepted in IDLE
//   ram_we         : 1 = write-back, 0 = read/fill
//   ram_address    : byte address, must be 8-byte aligned
//   ram_write_data : write-back data
//   ram_ready      : one-cycle completion pulse, LATENCY edges after acceptance
//   ram_read_data  : last aligned read result, held between reads
//   ram_error      : pulses with ram_ready when the request was misaligned
//   busy           : high from acceptance until the end of the ram_ready cycle
module main_memory
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ram_req,
  input  logic        ram_we,
  input  logic [31:0] ram_address,
  input  logic [63:0] ram_write_data,
  output logic        ram_ready,
  output logic [63:0] ram_read_data,
  output logic        ram_error,
  output logic        busy
);

  localparam int unsigned CNT_W = $clog2(LATENCY + 1);
  localparam int unsigned IDX_W = $clog2(DEPTH);

  state_e             state_r;
  state_e             state_s;
  logic [CNT_W-1:0]   cnt_r;
  logic               accept_s;
  logic               respond_s;
  logic               cap_we_r;
  logic [IDX_W-1:0]   cap_idx_r;
  logic [63:0]        cap_data_r;
  logic               misaligned_r;
  logic               ready_r;
  logic               error_r;
  logic               busy_r;
  logic               mem_en_s;

  // Next-state logic. Every request passes through WAIT, whose counter is
  // loaded with LATENCY-1 and runs down to zero, so the RESPOND-entry edge
  // lands exactly LATENCY edges after acceptance (also for LATENCY=1).
  always_comb begin
    state_s   = state_r;
    accept_s  = 1'b0;
    respond_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (ram_req) begin
          accept_s = 1'b1;
          state_s  = WAIT;
        end else begin
          state_s  = IDLE;
        end
      end
      WAIT: begin
        if (cnt_r == {CNT_W{1'b0}}) begin
          respond_s = 1'b1;
          state_s   = RESPOND;
        end else begin
          state_s   = WAIT;
        end
      end
      RESPOND: state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Latency counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (accept_s) begin
      cnt_r <= CNT_W'(LATENCY - 1);
    end else if (state_r == WAIT && cnt_r != {CNT_W{1'b0}}) begin
      cnt_r <= cnt_r - CNT_W'(1);
    end
  end

  // Request capture; inputs are ignored until the next acceptance.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cap_we_r     <= 1'b0;
      cap_idx_r    <= {IDX_W{1'b0}};
      cap_data_r   <= 64'd0;
      misaligned_r <= 1'b0;
    end else if (accept_s) begin
      cap_we_r     <= ram_we;
      cap_idx_r    <= IDX_W'(addr_to_index(ram_address, DEPTH));
      cap_data_r   <= ram_write_data;
      misaligned_r <= (ram_address & (WORD_BYTES - 32'd1)) != 32'd0;
    end
  end

  // Registered handshake outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_r <= 1'b0;
      error_r <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      ready_r <= respond_s;
      error_r <= respond_s && misaligned_r;
      if (accept_s) begin
        busy_r <= 1'b1;
      end else if (state_r == RESPOND) begin
        busy_r <= 1'b0;
      end
    end
  end

  // A misaligned request completes without touching the array.
  assign mem_en_s = respond_s && !misaligned_r;

  mem_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_mem_array (
    .clk   (clk),
    .rst   (rst),
    .en    (mem_en_s),
    .we    (cap_we_r),
    .index (cap_idx_r),
    .wdata (cap_data_r),
    .rdata (ram_read_data)
  );

  assign ram_ready = ready_r;
  assign ram_error = error_r;
  assign busy      = busy_r;

endmodule
